// File: rtl/i2s_pkg.sv
// i2s_pkg: shared state type and synchronizer depth for the I2S target receiver
package i2s_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LEFT,
        RIGHT
    } i2s_tgt_state_t;

    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/i2s_sync_edge.sv
// i2s_sync_edge: multi-flop synchronizer with an optional rising-edge strobe
module i2s_sync_edge
    import i2s_pkg::*;
#(
    parameter bit EDGE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise
);

    logic [SYNC_DEPTH-1:0] sr;

    // move the asynchronous input through the synchronizer chain
    always_ff @(posedge clk) begin
        if (rst) sr <= '0;
        else     sr <= {sr[SYNC_DEPTH-2:0], d};
    end

    assign q = sr[SYNC_DEPTH-1];

    generate
        if (EDGE) begin : g_edge
            logic q_d;
            // delayed copy of the synced level so a 0->1 step becomes a one-cycle strobe
            always_ff @(posedge clk) begin
                if (rst) q_d <= 1'b0;
                else     q_d <= q;
            end
            assign rise = q & ~q_d;
        end else begin : g_level
            assign rise = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/i2s_target_receiver.sv
// i2s_target_receiver: clock-follower I2S receiver; I2S_TARGET_FRAME_CHECK_EN adds slot-length framing checks
module i2s_target_receiver
    import i2s_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SLOT_MAX = 32
) (
    input  logic             mclk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             ws,
    input  logic             sd_rx,
    output logic [WIDTH-1:0] rx_data_l,
    output logic [WIDTH-1:0] rx_data_r,
    output logic             rx_valid,
    output logic             locked,
    output logic             frame_err
);

    localparam int CW = $clog2(SLOT_MAX + 1);
    localparam logic [WIDTH-1:0] TOP_BIT = WIDTH'(1) << (WIDTH - 1);

    i2s_tgt_state_t state, state_d;
    logic             rise, ws_s, sd_s, ws_prev;
    logic             ws_rise_unused, sd_rise_unused;
    logic [CW-1:0]    bitcnt, bitcnt_inc;
    logic [WIDTH-1:0] shift, cap, stage_l;
    logic             ws_fall, ws_up, commit, stage_ld, clr;

    i2s_sync_edge #(.EDGE(1'b1)) u_sclk (.clk(mclk), .rst(rst), .d(sclk),  .q(),     .rise(rise));
    i2s_sync_edge #(.EDGE(1'b0)) u_ws   (.clk(mclk), .rst(rst), .d(ws),    .q(ws_s), .rise(ws_rise_unused));
    i2s_sync_edge #(.EDGE(1'b0)) u_sd   (.clk(mclk), .rst(rst), .d(sd_rx), .q(sd_s), .rise(sd_rise_unused));

    assign ws_fall    = ws_prev & ~ws_s;
    assign ws_up      = ~ws_prev & ws_s;
    assign bitcnt_inc = (bitcnt == CW'(SLOT_MAX)) ? bitcnt : bitcnt + 1'b1;
    // a bit position past WIDTH shifts the marker out, so surplus bits vanish
    assign cap        = shift | ({WIDTH{sd_s}} & (TOP_BIT >> bitcnt));
    assign locked     = (state != IDLE);

`ifdef I2S_TARGET_FRAME_CHECK_EN
    logic [CW-1:0] left_len;
    logic          err, err_q;
`endif

    // slot sequencing: a ws change marks the current bit as the last of its slot
    always_comb begin
        state_d  = state;
        commit   = 1'b0;
        stage_ld = 1'b0;
        clr      = 1'b0;
`ifdef I2S_TARGET_FRAME_CHECK_EN
        err      = 1'b0;
`endif
        if (rise) begin
            case (state)
                IDLE:    if (ws_fall) begin state_d = LEFT;  clr = 1'b1; end
                LEFT:    if (ws_up)   begin state_d = RIGHT; clr = 1'b1; stage_ld = 1'b1; end
                RIGHT:   if (ws_fall) begin state_d = LEFT;  clr = 1'b1; commit   = 1'b1; end
                default: state_d = IDLE;
            endcase
`ifdef I2S_TARGET_FRAME_CHECK_EN
            if (state != IDLE && (bitcnt == CW'(SLOT_MAX) ||
                (state == RIGHT && ws_fall && bitcnt != left_len))) begin
                state_d = IDLE;
                commit  = 1'b0;
                err     = 1'b1;
            end
`endif
        end
    end

    // state register
    always_ff @(posedge mclk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // shift path, left staging and the committed output pair
    always_ff @(posedge mclk) begin
        if (rst) begin
            ws_prev   <= 1'b0;
            bitcnt    <= '0;
            shift     <= '0;
            stage_l   <= '0;
            rx_data_l <= '0;
            rx_data_r <= '0;
            rx_valid  <= 1'b0;
        end else begin
            rx_valid <= commit;
            if (rise) begin
                ws_prev <= ws_s;
                shift   <= clr ? '0 : cap;
                bitcnt  <= clr ? '0 : bitcnt_inc;
            end
            if (stage_ld) stage_l <= cap;
            if (commit) begin
                rx_data_l <= stage_l;
                rx_data_r <= cap;
            end
        end
    end

`ifdef I2S_TARGET_FRAME_CHECK_EN
    // remember the left slot length and latch any framing error until reset
    always_ff @(posedge mclk) begin
        if (rst) begin
            left_len <= '0;
            err_q    <= 1'b0;
        end else begin
            if (stage_ld) left_len <= bitcnt;
            if (err)      err_q    <= 1'b1;
        end
    end
    assign frame_err = err_q;
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_target_receiver.sv
// tb_i2s_target_receiver: directed I2S frames driven at mclk/8 with hand-computed expectations
module tb_i2s_target_receiver;

    logic       mclk  = 1'b0;
    logic       rst   = 1'b1;
    logic       sclk  = 1'b0;
    logic       ws    = 1'b1;
    logic       sd_rx = 1'b0;
    logic [7:0] rx_data_l, rx_data_r;
    logic       rx_valid, locked, frame_err;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         vcount   = 0;
    int         base;
    logic [7:0] cap_l [0:63];
    logic [7:0] cap_r [0:63];

    always #5 mclk = ~mclk;

    i2s_target_receiver #(.WIDTH(8), .SLOT_MAX(32)) dut (
        .mclk(mclk), .rst(rst), .sclk(sclk), .ws(ws), .sd_rx(sd_rx),
        .rx_data_l(rx_data_l), .rx_data_r(rx_data_r), .rx_valid(rx_valid),
        .locked(locked), .frame_err(frame_err)
    );

    // record every cycle rx_valid is high; a stretched pulse inflates the count
    always @(negedge mclk) begin
        if (rx_valid) begin
            cap_l[vcount % 64] = rx_data_l;
            cap_r[vcount % 64] = rx_data_r;
            vcount++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic w, input logic b);
        ws    = w;
        sd_rx = b;
        #40 sclk = 1'b1;
        #40 sclk = 1'b0;
    endtask

    // ws flips on the last bit of the slot (I2S one-bit delay)
    task automatic send_slot(input logic w, input logic [7:0] word, input int len, input int from, input int to);
        for (int j = from; j < to; j++)
            send_bit((j == len - 1) ? ~w : w, (j < 8) ? word[3'(7 - j)] : 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] l, input logic [7:0] r, input int ll, input int rl);
        send_slot(1'b0, l, ll, 0, ll);
        send_slot(1'b1, r, rl, 0, rl);
    endtask

    task automatic settle();
        repeat (8) @(posedge mclk);
        @(negedge mclk);
    endtask

    initial begin
        repeat (4) @(posedge mclk);
        @(negedge mclk);
        check("rst_l", rx_data_l, 8'h00);
        check("rst_r", rx_data_r, 8'h00);
        check("rst_valid", rx_valid, 0);
        check("rst_locked", locked, 0);
        check("rst_ferr", frame_err, 0);
        rst = 1'b0;

        repeat (10) send_bit(1'b1, 1'b1);
        settle();
        check("align_prelock", locked, 0);
        send_bit(1'b0, 1'b1);
        settle();
        check("align_lock", locked, 1);
        check("align_novalid", vcount, 0);

        send_frame(8'hA5, 8'h3C, 32, 32);
        settle();
        check("basic_cnt", vcount, 1);
        check("basic_l", rx_data_l, 8'hA5);
        check("basic_r", rx_data_r, 8'h3C);
        check("basic_pulse_low", rx_valid, 0);

        send_frame(8'h5A, 8'hC3, 32, 32);
        settle();
        check("basic2_cnt", vcount, 2);
        check("basic2_l", rx_data_l, 8'h5A);
        check("basic2_r", rx_data_r, 8'hC3);

        send_frame(8'hB0, 8'h70, 4, 4);
        settle();
        check("short_cnt", vcount, 3);
        check("short_l", rx_data_l, 8'hB0);
        check("short_r", rx_data_r, 8'h70);

        send_slot(1'b0, 8'hFF, 32, 0, 6);
        @(posedge mclk) #1 rst = 1'b1;
        @(posedge mclk) #1 rst = 1'b0;
        @(negedge mclk);
        check("mid_rst_l", rx_data_l, 8'h00);
        check("mid_rst_r", rx_data_r, 8'h00);
        check("mid_rst_valid", rx_valid, 0);
        check("mid_rst_locked", locked, 0);
        check("mid_rst_ferr", frame_err, 0);
        send_slot(1'b0, 8'hFF, 32, 6, 32);
        send_slot(1'b1, 8'hEE, 32, 0, 32);
        settle();
        check("relock_cnt", vcount, 3);
        check("relock_locked", locked, 1);
        send_frame(8'h11, 8'h22, 32, 32);
        settle();
        check("relock_data_cnt", vcount, 4);
        check("relock_l", rx_data_l, 8'h11);
        check("relock_r", rx_data_r, 8'h22);

        send_frame(8'h81, 8'h42, 32, 31);
        settle();
`ifdef I2S_TARGET_FRAME_CHECK_EN
        check("frame_ferr", frame_err, 1);
        check("frame_cnt", vcount, 4);
        check("frame_unlocked", locked, 0);
`else
        check("frame_ferr", frame_err, 0);
        check("frame_cnt", vcount, 5);
        check("frame_l", rx_data_l, 8'h81);
        check("frame_r", rx_data_r, 8'h42);
`endif

        send_frame(8'h99, 8'h66, 32, 32);
        settle();
        check("resync_locked", locked, 1);
        base = vcount;
        for (int i = 0; i < 16; i++)
            send_frame(8'(i), 8'(8'h80 | i), 32, 32);
        settle();
        check("b2b_cnt", vcount, base + 16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("b2b_l%0d", i), cap_l[(base + i) % 64], 8'(i));
            check($sformatf("b2b_r%0d", i), cap_r[(base + i) % 64], 8'(8'h80 | i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
